// File: rtl/eig_sched.sv
// Round-robin scheduler sharing one eigenvalue core between N_CH channels,
// with per-job cycle timeout supervision and a tagged response port.
module eig_sched #(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned CH_W    = 2,
  parameter int unsigned TIMEOUT = 1024,
  localparam int unsigned DW     = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_CH-1:0]      req_valid,
  output logic [N_CH-1:0]      req_ready,
  input  logic [N_CH*DW-1:0]   req_a0,
  input  logic [N_CH*DW-1:0]   req_a1,
  output logic                 core_start,
  output logic [DW-1:0]        core_a0,
  output logic [DW-1:0]        core_a1,
  output logic                 core_abort,
  input  logic                 core_done,
  input  logic [DW-1:0]        core_kappa,
  input  logic [DW-1:0]        core_inv_kappa,
  input  logic [2:0]           core_regime,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [CH_W-1:0]      rsp_ch,
  output logic [DW-1:0]        rsp_kappa,
  output logic [DW-1:0]        rsp_inv_kappa,
  output logic [2:0]           rsp_regime,
  output logic                 rsp_timeout,
  output logic [15:0]          timeout_cnt,
  output logic                 sched_busy
);

  localparam int unsigned SW    = CH_W + 1;
  localparam int unsigned TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] T_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CH_W-1:0]   last_q, last_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [DW-1:0]     a0_q, a0_d;
  logic [DW-1:0]     a1_q, a1_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [DW-1:0]     kappa_q, kappa_d;
  logic [DW-1:0]     inv_q, inv_d;
  logic [2:0]        regime_q, regime_d;
  logic              tout_q, tout_d;
  logic [15:0]       tcnt_q, tcnt_d;

  logic              found;
  logic [CH_W-1:0]   win;
  logic [SW-1:0]     slot;
  logic [DW-1:0]     a0_sel;
  logic [DW-1:0]     a1_sel;

  // Round-robin search starting just after the last grant, wrapping at N_CH
  always_comb begin : arb
    found = 1'b0;
    win   = '0;
    slot  = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      slot = {1'b0, last_q} + SW'(k) + SW'(1);
      if (slot >= SW'(N_CH)) slot = slot - SW'(N_CH);
      if (!found && req_valid[slot[CH_W-1:0]]) begin
        found = 1'b1;
        win   = slot[CH_W-1:0];
      end
    end
  end

  // Winner operand mux
  always_comb begin : opsel
    a0_sel = '0;
    a1_sel = '0;
    for (int unsigned j = 0; j < N_CH; j++) begin
      if (win == CH_W'(j)) begin
        a0_sel = req_a0[j*DW +: DW];
        a1_sel = req_a1[j*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : state_reg
    if (!rst_n) begin
      state_q  <= S_IDLE;
      last_q   <= CH_W'(N_CH - 1);
      ch_q     <= '0;
      a0_q     <= '0;
      a1_q     <= '0;
      timer_q  <= '0;
      kappa_q  <= '0;
      inv_q    <= '0;
      regime_q <= '0;
      tout_q   <= 1'b0;
      tcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      ch_q     <= ch_d;
      a0_q     <= a0_d;
      a1_q     <= a1_d;
      timer_q  <= timer_d;
      kappa_q  <= kappa_d;
      inv_q    <= inv_d;
      regime_q <= regime_d;
      tout_q   <= tout_d;
      tcnt_q   <= tcnt_d;
    end
  end

  always_comb begin : fsm_comb
    state_d    = state_q;
    last_d     = last_q;
    ch_d       = ch_q;
    a0_d       = a0_q;
    a1_d       = a1_q;
    timer_d    = timer_q;
    kappa_d    = kappa_q;
    inv_d      = inv_q;
    regime_d   = regime_q;
    tout_d     = tout_q;
    tcnt_d     = tcnt_q;
    req_ready  = '0;
    core_abort = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          req_ready[win] = 1'b1;
          a0_d           = a0_sel;
          a1_d           = a1_sel;
          last_d         = win;
          ch_d           = win;
          state_d        = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + TMR_W'(1);
        // A completion in the expiry cycle takes priority over the abort
        if (core_done) begin
          kappa_d  = core_kappa;
          inv_d    = core_inv_kappa;
          regime_d = core_regime;
          tout_d   = 1'b0;
          state_d  = S_RESP;
        end else if (timer_q == T_LAST) begin
          core_abort = 1'b1;
          kappa_d    = '0;
          inv_d      = '0;
          regime_d   = '0;
          tout_d     = 1'b1;
          if (tcnt_q != 16'hFFFF) tcnt_d = tcnt_q + 16'd1;
          state_d    = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign core_start    = (state_q == S_ISSUE);
  assign core_a0       = a0_q;
  assign core_a1       = a1_q;
  assign rsp_valid     = (state_q == S_RESP);
  assign rsp_ch        = ch_q;
  assign rsp_kappa     = kappa_q;
  assign rsp_inv_kappa = inv_q;
  assign rsp_regime    = regime_q;
  assign rsp_timeout   = tout_q;
  assign timeout_cnt   = tcnt_q;
  assign sched_busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_eig_sched.sv
// Directed bench for eig_sched: scoreboard of expected responses, core modelled inline.
module tb_eig_sched;

  localparam int unsigned NCH = 4;
  localparam int unsigned TMO = 8;

  typedef struct packed {
    logic [1:0]  ch;
    logic [31:0] kappa;
    logic [31:0] inv;
    logic [2:0]  regime;
    logic        tout;
  } rsp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NCH-1:0]   req_valid;
  logic [NCH-1:0]   req_ready;
  logic [NCH*32-1:0] req_a0;
  logic [NCH*32-1:0] req_a1;
  logic             core_start;
  logic [31:0]      core_a0;
  logic [31:0]      core_a1;
  logic             core_abort;
  logic             core_done;
  logic [31:0]      core_kappa;
  logic [31:0]      core_inv_kappa;
  logic [2:0]       core_regime;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [1:0]       rsp_ch;
  logic [31:0]      rsp_kappa;
  logic [31:0]      rsp_inv_kappa;
  logic [2:0]       rsp_regime;
  logic             rsp_timeout;
  logic [15:0]      timeout_cnt;
  logic             sched_busy;

  logic [31:0] a0_ch [NCH];
  logic [31:0] a1_ch [NCH];
  assign req_a0 = {a0_ch[3], a0_ch[2], a0_ch[1], a0_ch[0]};
  assign req_a1 = {a1_ch[3], a1_ch[2], a1_ch[1], a1_ch[0]};

  rsp_t        sb [$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  logic [15:0] exp_tcnt = '0;

  eig_sched #(.N_CH(NCH), .CH_W(2), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_a1(req_a1),
    .core_start(core_start), .core_a0(core_a0), .core_a1(core_a1),
    .core_abort(core_abort), .core_done(core_done),
    .core_kappa(core_kappa), .core_inv_kappa(core_inv_kappa), .core_regime(core_regime),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ch(rsp_ch),
    .rsp_kappa(rsp_kappa), .rsp_inv_kappa(rsp_inv_kappa), .rsp_regime(rsp_regime),
    .rsp_timeout(rsp_timeout), .timeout_cnt(timeout_cnt), .sched_busy(sched_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_req_ready"}, 64'(req_ready), 64'(0));
    chk({pfx, "_core_start"}, 64'(core_start), 64'(0));
    chk({pfx, "_core_abort"}, 64'(core_abort), 64'(0));
    chk({pfx, "_core_a0"}, 64'(core_a0), 64'(0));
    chk({pfx, "_core_a1"}, 64'(core_a1), 64'(0));
    chk({pfx, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
    chk({pfx, "_rsp_ch"}, 64'(rsp_ch), 64'(0));
    chk({pfx, "_rsp_kappa"}, 64'(rsp_kappa), 64'(0));
    chk({pfx, "_rsp_inv"}, 64'(rsp_inv_kappa), 64'(0));
    chk({pfx, "_rsp_regime"}, 64'(rsp_regime), 64'(0));
    chk({pfx, "_rsp_timeout"}, 64'(rsp_timeout), 64'(0));
    chk({pfx, "_timeout_cnt"}, 64'(timeout_cnt), 64'(0));
    chk({pfx, "_busy"}, 64'(sched_busy), 64'(0));
  endtask

  task automatic chk_rsp(input string pfx, input rsp_t e);
    chk({pfx, "_valid"}, 64'(rsp_valid), 64'(1));
    chk({pfx, "_ch"}, 64'(rsp_ch), 64'(e.ch));
    chk({pfx, "_kappa"}, 64'(rsp_kappa), 64'(e.kappa));
    chk({pfx, "_inv"}, 64'(rsp_inv_kappa), 64'(e.inv));
    chk({pfx, "_regime"}, 64'(rsp_regime), 64'(e.regime));
    chk({pfx, "_timeout"}, 64'(rsp_timeout), 64'(e.tout));
  endtask

  // One job from IDLE accept to response handshake; dd<0 means the core never completes
  task automatic run_job(input logic [3:0] valid, input int exp_ch, input int dd,
                         input logic [31:0] kap, input logic [31:0] inv, input logic [2:0] rg,
                         input int hold, input bit keep);
    rsp_t e;
    int   acc;
    int   lim;
    req_valid = valid;
    #1;
    chk("grant", 64'(req_ready), 64'(4'b0001 << exp_ch));
    e.ch = 2'(exp_ch);
    if (dd < 0) begin
      e.kappa = '0; e.inv = '0; e.regime = '0; e.tout = 1'b1;
    end else begin
      e.kappa = kap; e.inv = inv; e.regime = rg; e.tout = 1'b0;
    end
    sb.push_back(e);
    acc = cyc;
    step();
    if (!keep) req_valid = '0;
    chk("core_start", 64'(core_start), 64'(1));
    chk("core_a0", 64'(core_a0), 64'(a0_ch[exp_ch]));
    chk("core_a1", 64'(core_a1), 64'(a1_ch[exp_ch]));
    chk("ready_issue", 64'(req_ready), 64'(0));
    lim = (dd < 0) ? int'(TMO) : dd;
    for (int k = 1; k <= lim; k++) begin
      step();
      if (k == dd) begin
        core_done = 1'b1; core_kappa = kap; core_inv_kappa = inv; core_regime = rg;
      end
      #1;
      chk("abort", 64'(core_abort), 64'(dd < 0 && k == int'(TMO)));
      chk("start_wait", 64'(core_start), 64'(0));
      chk("rsp_early", 64'(rsp_valid), 64'(0));
      chk("ready_wait", 64'(req_ready), 64'(0));
    end
    if (dd < 0 && exp_tcnt != 16'hFFFF) exp_tcnt++;
    rsp_ready = (hold == 0);
    step();
    core_done = 1'b0; core_kappa = 32'hDEAD_BEEF; core_inv_kappa = 32'hBEEF_DEAD; core_regime = 3'b111;
    chk("latency", 64'(cyc - acc), 64'(lim + 2));
    e = sb.pop_front();
    chk_rsp("rsp", e);
    chk("tcnt", 64'(timeout_cnt), 64'(exp_tcnt));
    for (int h = 0; h < hold; h++) begin
      step();
      chk_rsp("hold", e);
      chk("hold_start", 64'(core_start), 64'(0));
      chk("hold_ready", 64'(req_ready), 64'(0));
    end
    rsp_ready = 1'b1;
    step();
    chk("rsp_drop", 64'(rsp_valid), 64'(0));
    chk("idle_busy", 64'(sched_busy), 64'(0));
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b1; core_done = 1'b0;
    core_kappa = '0; core_inv_kappa = '0; core_regime = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      a0_ch[i] = 32'h1000_0000 + 32'(i);
      a1_ch[i] = 32'h2000_0000 + 32'(i);
    end
    a0_ch[2] = 32'h0004_0000;
    a1_ch[2] = 32'h0001_0000;
    step(); step();
    chk_zero("reset");
    rst_n = 1'b1;
    step();

    // Single channel, fast core: done 5 cycles after start
    run_job(4'b0100, 2, 5, 32'h0002_0000, 32'h0000_8000, 3'b100, 0, 1'b0);

    // Timeout with a silent core
    run_job(4'b1000, 3, -1, 32'h0, 32'h0, 3'b000, 0, 1'b0);
    chk("tcnt_after_timeout", 64'(timeout_cnt), 64'(1));

    // Continuous requests from all channels, rsp_ready held high
    for (int i = 0; i < 6; i++)
      run_job(4'b1111, i % 4, 2 + i, 32'h0001_0000 * 32'(i + 1), 32'h0000_4000 + 32'(i),
              3'b001 << (i % 3), 0, 1'b1);
    req_valid = '0;

    // Completion in the expiry cycle
    run_job(4'b0001, 0, int'(TMO), 32'h0003_0000, 32'h0000_5555, 3'b010, 0, 1'b0);
    chk("tcnt_collision", 64'(timeout_cnt), 64'(1));

    // Stray completion while idle
    core_done = 1'b1; core_kappa = 32'h7777_7777; core_inv_kappa = 32'h1; core_regime = 3'b001;
    #1;
    chk("stray_abort", 64'(core_abort), 64'(0));
    step();
    core_done = 1'b0;
    chk("stray_rsp", 64'(rsp_valid), 64'(0));
    chk("stray_busy", 64'(sched_busy), 64'(0));
    chk("stray_start", 64'(core_start), 64'(0));
    chk("stray_kappa", 64'(rsp_kappa), 64'(32'h0003_0000));
    chk("stray_tcnt", 64'(timeout_cnt), 64'(1));

    // Backpressure with ch1 and ch3 pending
    run_job(4'b1010, 1, 3, 32'h0005_0000, 32'h0000_3333, 3'b100, 10, 1'b1);
    run_job(4'b1010, 3, 4, 32'h0006_0000, 32'h0000_2AAA, 3'b001, 0, 1'b0);

    // Reset asserted while a job is in WAIT
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    chk("pre_reset_start", 64'(core_start), 64'(1));
    step(); step();
    chk("pre_reset_busy", 64'(sched_busy), 64'(1));
    rst_n = 1'b0;
    #1;
    chk_zero("rst_async");
    step();
    chk_zero("rst_edge");
    rst_n = 1'b1;
    exp_tcnt = '0;
    run_job(4'b1111, 0, 3, 32'h0008_0000, 32'h0000_2000, 3'b010, 0, 1'b0);

    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eig_sched.md
# eig_sched

Round-robin scheduler that shares one eigenvalue core (alpha/beta → kappa, inv_kappa, regime) between `N_CH` watchdog channels. It accepts coefficient pairs from requesting channels and serialises them onto the single core, one job at a time. It also supervises each job with a cycle timeout and returns tagged results to a common response port. It sits between the per-channel coefficient estimators and the eig_core instance.

## Interface
- `N_CH`, default 4: number of requesting channels, 2..16.
- `CH_W`, default 2: channel index width; must equal clog2(`N_CH`).
- `TIMEOUT`, default 1024: maximum core cycles per job before abort, ≥ 2.
- `clk`, input, 1: clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `req_valid`, input, `N_CH`: per-channel job request.
- `req_ready`, output, `N_CH`: one-hot grant; a job is accepted when `req_valid[i] & req_ready[i]`.
- `req_a0`, input, `N_CH`*32: signed alpha per channel; channel i is in bits [32i+31:32i].
- `req_a1`, input, `N_CH`*32: signed beta per channel, packed the same way.
- `core_start`, output, 1: one-cycle pulse that launches the core.
- `core_a0`, output, 32: alpha operand; stable from `core_start` until the job ends.
- `core_a1`, output, 32: beta operand; stable from `core_start` until the job ends.
- `core_abort`, output, 1: one-cycle pulse on timeout; the core returns to idle.
- `core_done`, input, 1: one-cycle pulse; the core results are valid in the same cycle.
- `core_kappa`, input, 32: signed Q16.16 kappa.
- `core_inv_kappa`, input, 32: signed Q16.16 inverse of kappa.
- `core_regime`, input, 3: one-hot regime, 100 = over, 010 = critical, 001 = under.
- `rsp_valid`, output, 1: response available.
- `rsp_ready`, input, 1: response consumed.
- `rsp_ch`, output, `CH_W`: channel that owns the response.
- `rsp_kappa`, output, 32: result kappa.
- `rsp_inv_kappa`, output, 32: result inv_kappa.
- `rsp_regime`, output, 3: result regime.
- `rsp_timeout`, output, 1: the job was aborted by timeout.
- `timeout_cnt`, output, 16: saturating count of aborted jobs.
- `sched_busy`, output, 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - Arbitration is round-robin, starting at `(last_grant+1) mod N_CH` and wrapping.
  - If any `req_valid` is high, `req_ready` is driven combinationally for the winner only, in this cycle.
  - The winner's a0/a1 are registered into `core_a0`/`core_a1`, the winner index is registered, `last_grant` is set to the winner, and the FSM goes to ISSUE.
  - `req_ready` is all-zero in every other state.
- **ISSUE**
  - `core_start` = 1 for exactly this cycle.
  - The timer is cleared to 0, and the FSM goes to WAIT.
- **WAIT**
  - The timer increments every cycle.
  - If `core_done` is high: capture kappa, inv_kappa and regime, set `rsp_timeout` = 0, go to RESP.
  - Else if timer == `TIMEOUT`-1: pulse `core_abort`, load `rsp_kappa` = 0, `rsp_inv_kappa` = 0, `rsp_regime` = 000 and `rsp_timeout` = 1, increment `timeout_cnt` (saturating at FFFF), go to RESP.
  - If `core_done` and timer expiry occur in the same cycle, `core_done` wins: no abort, no count.
- **RESP**
  - `rsp_valid` = 1 and all `rsp_*` fields are held stable.
  - On `rsp_ready` = 1, go to IDLE.
- Arbitration runs in the IDLE state only, so a new grant happens at the earliest in the cycle after the response handshake.
- `core_done` outside WAIT, for example a late completion after an abort, is ignored and has no effect.
- A requester dropping `req_valid` before it is granted is legal; no state is kept for it.
- Reset values:
  - FSM = IDLE.
  - `last_grant` = `N_CH`-1, so channel 0 wins first.
  - All outputs 0: `req_ready`, `core_start`, `core_abort`, `core_a0`, `core_a1`, `rsp_*`, `timeout_cnt`, `sched_busy`.
- Asserting reset mid-job returns to IDLE immediately.
  - No abort pulse is issued.
  - The in-flight response is lost.

## Timing
- Accept in cycle t (IDLE).
- `core_start` in cycle t+1.
- A `core_done` pulse in cycle d ≥ t+2 gives `rsp_valid` from cycle d+1.
- Timeout path:
  - `core_abort` is pulsed in cycle t+1+`TIMEOUT`.
  - `rsp_valid` rises in cycle t+2+`TIMEOUT`.
- Response handshake in cycle r gives IDLE at r+1; the next accept is possible at r+1.
- Minimum job-to-job interval: 4 cycles (accept, ISSUE, done, response).
- `core_a0` and `core_a1` change only on an IDLE accept.

## Test plan
- **Single channel, fast core:**
  - Stimulus: ch2 requests with a0 = 0x00040000, a1 = 0x00010000; core_done 5 cycles after `core_start` with kappa = 0x00020000.
  - Required: `rsp_valid` with ch = 2, kappa = 0x00020000 and timeout = 0; accept-to-`rsp_valid` = 7 cycles.
- **All four channels request continuously, `rsp_ready` tied high:**
  - Required: grant order 0, 1, 2, 3, 0, 1.
  - Required: each `req_ready` is a single one-hot cycle, with no overlap between jobs.
- **Timeout, `TIMEOUT` = 8, core never completes:**
  - Required: `core_abort` exactly 8 cycles after `core_start`.
  - Required: the response has timeout = 1, kappa = 0 and regime = 000; `timeout_cnt` = 1.
- **Collision and late completion, `TIMEOUT` = 8:**
  - Stimulus: `core_done` in the expiry cycle.
  - Required: normal response, no abort, `timeout_cnt` unchanged.
  - Stimulus: a stray `core_done` later, while in IDLE.
  - Required: ignored.
- **Backpressure:**
  - Stimulus: `rsp_ready` low for 10 cycles while ch1 and ch3 are pending.
  - Required: `rsp_*` stable and no new `core_start`; ch3 is served after ch1 once the response is released.
- **Reset during WAIT:**
  - Required: all outputs 0 on the next edge, and ch0 wins the first grant after release.
